// File: rtl/mc_multipage_controller.sv
// mc_multipage_controller: burst memory controller serving NUM_PAGES pages from BASE_PAGE on a multiplexed bus
module mc_multipage_controller #(
  parameter int                   DATA_W      = 16,
  parameter int                   PAGE_BITS   = 4,
  parameter logic [PAGE_BITS-1:0] BASE_PAGE   = 4'h2,
  parameter int                   NUM_PAGES   = 2,
  parameter int                   OFFSET_BITS = 8,
  parameter int                   BURST_LEN   = 4,
  parameter int                   WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              resetL,
  input  logic              addr_valid,
  input  logic              rw,
  input  logic [DATA_W-1:0] ad_in,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              busy,
  output logic              prot_err
);
  localparam int PW    = NUM_PAGES > 1 ? $clog2(NUM_PAGES) : 1;
  localparam int CMAX  = BURST_LEN > WAIT_STATES ? BURST_LEN : WAIT_STATES;
  localparam int CW    = CMAX > 1 ? $clog2(CMAX) : 1;
  localparam int DEPTH = NUM_PAGES << OFFSET_BITS;
  typedef enum logic [1:0] {IDLE, WAIT, XFER, SKIP} state_t;
  state_t                    state_q, state_d;
  logic                      rw_q, rw_d, hit_q, hit_d, oe_q, oe_d, err_q, err_d, load;
  logic [PW-1:0]             pidx_q, pidx_d;
  logic [OFFSET_BITS-1:0]    off_q, off_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]         out_q, out_d, rd_data;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic [31:0]               page;
  logic                      hit, last_beat, last_wait;
  logic [PW+OFFSET_BITS-1:0] rd_idx;
  assign page      = 32'(ad_in[DATA_W-1 -: PAGE_BITS]);
  assign hit       = page >= 32'(BASE_PAGE) && page < 32'(BASE_PAGE) + 32'(NUM_PAGES);
  assign last_beat = cnt_q == CW'(BURST_LEN - 1);
  assign last_wait = cnt_q == CW'(WAIT_STATES - 1);
  // ad_out is registered, so the read address runs one beat ahead of the access address
  assign rd_idx  = state_q == IDLE ? {PW'(page - 32'(BASE_PAGE)), ad_in[OFFSET_BITS-1:0]}
                 : {pidx_q, state_q == WAIT ? off_q : off_q + OFFSET_BITS'(1)};
  assign rd_data = mem[rd_idx];
  assign ad_out   = out_q;
  assign ad_oe    = oe_q;
  assign prot_err = err_q;
  assign busy     = state_q == XFER || (state_q == WAIT && hit_q);
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    hit_d   = hit_q;
    pidx_d  = pidx_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    err_d   = err_q | (addr_valid && state_q != IDLE);
    unique case (state_q)
      IDLE: if (addr_valid) begin
        rw_d    = rw;
        hit_d   = hit;
        pidx_d  = PW'(page - 32'(BASE_PAGE));
        off_d   = ad_in[OFFSET_BITS-1:0];
        cnt_d   = '0;
        state_d = WAIT_STATES > 0 ? WAIT : hit ? XFER : SKIP;
        load    = WAIT_STATES == 0 && hit && rw;
      end
      WAIT: if (last_wait) begin
        cnt_d   = '0;
        state_d = hit_q ? XFER : SKIP;
        load    = hit_q && rw_q;
      end else cnt_d = cnt_q + CW'(1);
      XFER: begin
        off_d   = off_q + OFFSET_BITS'(1);
        cnt_d   = last_beat ? '0 : cnt_q + CW'(1);
        state_d = last_beat ? IDLE : XFER;
        load    = !last_beat && rw_q;
      end
      SKIP: begin
        cnt_d   = last_beat ? '0 : cnt_q + CW'(1);
        state_d = last_beat ? IDLE : SKIP;
      end
      default: state_d = IDLE;
    endcase
    oe_d  = load;
    out_d = load ? rd_data : '0;
  end
  always_ff @(posedge clk) begin
    if (!resetL) begin
      state_q <= IDLE;
      rw_q    <= 1'b0;
      hit_q   <= 1'b0;
      pidx_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      hit_q   <= hit_d;
      pidx_q  <= pidx_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (resetL && state_q == XFER && !rw_q) mem[{pidx_q, off_q}] <= ad_in;
  end
endmodule

// File: tb/tb_mc_multipage_controller.sv
// tb_mc_multipage_controller: cycle-vector bench for the default and a wait-state controller instance
module tb_mc_multipage_controller;
  logic        clk = 1'b0, resetL = 1'b0, addr_valid = 1'b0, rw = 1'b0;
  logic [15:0] ad_in = '0, out0, out1;
  logic        oe0, oe1, busy0, busy1, err0, err1;
  always #5 clk = ~clk;
  mc_multipage_controller u0 (
    .clk(clk), .resetL(resetL), .addr_valid(addr_valid), .rw(rw), .ad_in(ad_in),
    .ad_out(out0), .ad_oe(oe0), .busy(busy0), .prot_err(err0)
  );
  mc_multipage_controller #(.WAIT_STATES(2), .BURST_LEN(2)) u1 (
    .clk(clk), .resetL(resetL), .addr_valid(addr_valid), .rw(rw), .ad_in(ad_in),
    .ad_out(out1), .ad_oe(oe1), .busy(busy1), .prot_err(err1)
  );
  typedef struct {
    logic        av, rw;
    logic [15:0] ad;
    logic        rl, ck, oe;
    logic [15:0] out;
    logic        busy, err;
    int          grp;
  } vec_t;
  vec_t tbl[$];
  logic err_exp = 1'b0;
  int   grp = 0, errors = 0, checks = 0;
  task automatic v(input logic av, rw_v, input logic [15:0] ad, input logic rl, ck, oe,
                   input logic [15:0] out, input logic bsy, er);
    vec_t t;
    t = '{av, rw_v, ad, rl, ck, oe, out, bsy, er, grp};
    tbl.push_back(t);
  endtask
  task automatic wr(input logic [15:0] a, d0, d1, d2, d3, input logic hit);
    logic [15:0] d[4];
    d = '{d0, d1, d2, d3};
    v(1, 0, a, 1, 1, 0, 16'h0, 0, err_exp);
    for (int i = 0; i < 4; i++) v(0, 0, d[i], 1, 1, 0, 16'h0, hit, err_exp);
  endtask
  task automatic rd(input logic [15:0] a, e0, e1, e2, e3, input logic [3:0] m);
    logic [15:0] e[4];
    e = '{e0, e1, e2, e3};
    v(1, 1, a, 1, 1, 0, 16'h0, 0, err_exp);
    for (int i = 0; i < 4; i++) v(0, 1, 16'h0, 1, m[i], 1, e[i], 1, err_exp);
  endtask
  task automatic run(input bit sel);
    logic [15:0] o;
    logic        oe, b, er;
    foreach (tbl[i]) begin
      @(negedge clk);
      o  = sel ? out1 : out0;
      oe = sel ? oe1 : oe0;
      b  = sel ? busy1 : busy0;
      er = sel ? err1 : err0;
      checks++;
      if (oe !== tbl[i].oe || b !== tbl[i].busy || er !== tbl[i].err || (tbl[i].ck && o !== tbl[i].out)) begin
        errors++;
        $display("FAIL grp%0d vec%0d dut%0d: got oe=%b out=%h busy=%b err=%b, want oe=%b out=%h busy=%b err=%b",
                 tbl[i].grp, i, sel, oe, o, b, er, tbl[i].oe, tbl[i].out, tbl[i].busy, tbl[i].err);
      end
      addr_valid = tbl[i].av;
      rw         = tbl[i].rw;
      ad_in      = tbl[i].ad;
      resetL     = tbl[i].rl;
    end
  endtask
  initial begin
    grp = 1;
    v(0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 0);
    wr(16'h2004, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 1);
    wr(16'h2040, 16'hF000, 16'hF001, 16'hF002, 16'hF003, 1);
    wr(16'h2010, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 1);
    rd(16'h2010, 16'hA000, 16'hA001, 16'hA002, 16'hA003, 4'hF);
    grp = 2;
    wr(16'h20FE, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 1);
    wr(16'h30FE, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1);
    rd(16'h3000, 16'h3333, 16'h4444, 16'h0, 16'h0, 4'b0011);
    rd(16'h30FE, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 4'hF);
    rd(16'h20FE, 16'hB000, 16'hB001, 16'hB002, 16'hB003, 4'hF);
    grp = 3;
    wr(16'h5000, 16'h0BAD, 16'h0BAD, 16'h2004, 16'h0BAD, 0);
    rd(16'h2004, 16'hC000, 16'hC001, 16'hC002, 16'hC003, 4'hF);
    grp = 4;
    wr(16'h2000, 16'hD000, 16'hD001, 16'hD002, 16'hD003, 1);
    v(1, 1, 16'h2000, 1, 1, 0, 16'h0, 0, 0);
    v(0, 1, 16'h0, 1, 1, 1, 16'hD000, 1, 0);
    v(0, 1, 16'h0, 1, 1, 1, 16'hD001, 1, 0);
    v(1, 1, 16'h2020, 1, 1, 1, 16'hD002, 1, 0);
    err_exp = 1'b1;
    v(0, 1, 16'h0, 1, 1, 1, 16'hD003, 1, 1);
    v(0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 1);
    grp = 5;
    v(1, 0, 16'h2040, 1, 1, 0, 16'h0, 0, 1);
    v(0, 0, 16'hE000, 1, 1, 0, 16'h0, 1, 1);
    v(0, 0, 16'hE001, 1, 1, 0, 16'h0, 1, 1);
    v(0, 0, 16'hE002, 0, 1, 0, 16'h0, 1, 1);
    err_exp = 1'b0;
    rd(16'h2040, 16'hE000, 16'hE001, 16'hF002, 16'hF003, 4'hF);
    v(0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 0);
    repeat (2) @(negedge clk);
    run(0);
    tbl.delete();
    grp = 6;
    v(0, 0, 16'h0, 0, 1, 0, 16'h0, 0, 0);
    v(1, 0, 16'h2000, 1, 1, 0, 16'h0, 0, 0);
    v(0, 0, 16'h0, 1, 1, 0, 16'h0, 1, 0);
    v(0, 0, 16'h0, 1, 1, 0, 16'h0, 1, 0);
    v(0, 0, 16'h7001, 1, 1, 0, 16'h0, 1, 0);
    v(0, 0, 16'h7002, 1, 1, 0, 16'h0, 1, 0);
    v(1, 1, 16'h2000, 1, 1, 0, 16'h0, 0, 0);
    v(0, 1, 16'h0, 1, 1, 0, 16'h0, 1, 0);
    v(0, 1, 16'h0, 1, 1, 0, 16'h0, 1, 0);
    v(0, 1, 16'h0, 1, 1, 1, 16'h7001, 1, 0);
    v(0, 1, 16'h0, 1, 1, 1, 16'h7002, 1, 0);
    v(0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 0);
    v(0, 0, 16'h0, 1, 1, 0, 16'h0, 0, 0);
    run(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
